aes_dec_redundancy: RTL and testbench
=====================================

# aes_dec_redundancy

- Fault-tolerant AES-128 decryption wrapper.
- Accepts a ciphertext/key pair over a valid/ready handshake.
- Decrypts on two aes_inv_core instances and compares the results. On mismatch it runs a third instance and takes a majority vote, retrying the whole decryption up to MAX_RETRY times before declaring a fatal fault.
- Sits on the receive side of the protected link, consuming ciphertext produced by the redundant encryption path.

## Interface
- MAX_RETRY, default 2: full A/B re-runs allowed after an unresolved vote.
- TIMEOUT, default 64: cycles allowed from core start to done before a fatal fault.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ciphertext_in/key_in valid.
- in_ready  out  1  block idle and accepting.
- ciphertext_in  in  128  ciphertext.
- key_in  in  128  AES-128 key.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- plaintext_out  out  128  decrypted data; zero whenever out_valid=0.
- fault_detected  out  1  a single-core disagreement was corrected (qualified by out_valid).
- fault_fatal  out  1  no majority or timeout; plaintext_out is zero (qualified by out_valid).
- err_count  out  16  saturating count of transactions with fault_detected or fault_fatal.

## Operation
- **FSM states:** IDLE, RUN_AB, CMP, RUN_C, VOTE, OUT.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready: latch ciphertext/key, clear retry counter, go to RUN_AB.
- **RUN_AB:**
  - start is a one-cycle pulse to cores A and B.
  - Each core's done is captured in a sticky flag, since the two may finish on different cycles.
  - When both flags are set, go to CMP.
- **CMP:**
  - A==B: go to OUT with result A, no fault.
  - A!=B: pulse start to core C, go to RUN_C.
- **RUN_C:** on C done, go to VOTE.
- **VOTE:**
  - C==A: output A.
  - Else C==B: output B.
  - Either case sets fault_detected=1.
  - No match and retry<MAX_RETRY: retry+1, return to RUN_AB (A and B restarted).
  - No match and retry budget exhausted: go to OUT with fault_fatal=1 and zero plaintext.
- **Timeout:**
  - A timeout counter resets at every start pulse.
  - Reaching TIMEOUT in RUN_AB or RUN_C goes to OUT with fault_fatal=1.
- **OUT:**
  - out_valid=1.
  - plaintext_out, fault_detected and fault_fatal are held stable until out_ready.
  - On out_valid&out_ready: clear all outputs, go to IDLE.
- **err_count:**
  - Increments by 1 on the out_valid&out_ready handshake of a faulty transaction.
  - Saturates at 16'hFFFF.
- **Inputs outside IDLE:** in_valid is ignored and ciphertext_in is not sampled.
- **aes_inv_core contract:**
  - Ports: clk, rst_n, start, ct_in, key_in, pt_out, done.
  - done is a one-cycle pulse after a fixed latency L.
  - pt_out is held from done until the next start.

## Timing
- **Reset values:**
  - State IDLE; in_ready=1.
  - out_valid=0, plaintext_out=0, fault_detected=0, fault_fatal=0, err_count=0.
  - Retry and timeout counters 0; done flags cleared.
- **Fault-free latency:**
  - Handshake at cycle T.
  - start high at T+1.
  - done at T+1+L.
  - CMP at T+2+L.
  - out_valid at T+3+L.
- **Single-fault latency:** an extra L+2 cycles (RUN_C plus VOTE).
- **Back-to-back throughput:** out_ready=1 in the first OUT cycle gives IDLE the next cycle. Earliest next accept is one cycle after the output handshake.
- **Reset mid-operation:** asynchronously clears the FSM and all outputs, and also resets the cores (shared rst_n). No partial result is ever presented.
- **Simultaneous events:** done and timeout expiry in the same cycle resolve to done (not a fault).

## Structure
- **Package aes_red_pkg:**
  - State enum.
  - BLK_W=128 and ERR_W=16 constants.
  - ZERO_BLK constant.
- **Sub-module tmr_vote128 (combinational):**
  - Inputs: a, b, c.
  - Outputs: ab_eq, ca_eq, cb_eq, sel[1:0].
- **Instances:** three aes_inv_core instances (A, B, C).
- **Remaining logic:** the FSM, counters and output registers live in the top module.

## Test plan
Use FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. The bench core model has fault injection.

- No faults -> plaintext_out=00112233445566778899aabbccddeeff at T+3+L, flags 0, err_count 0.
- Flip bit 0 of core B output -> correct plaintext, fault_detected=1, out_valid at T+5+2L, err_count=1.
- A, B, C all differ on every run, MAX_RETRY=2 -> three A/B runs, then fault_fatal=1, plaintext_out=0, err_count=1.
- Core A never asserts done -> fault_fatal=1 after TIMEOUT cycles; in_ready stays 0 throughout.
- Hold out_ready=0 for 10 cycles -> outputs stable; new in_valid ignored; accept occurs only after the output handshake.
- rst_n low mid RUN_C -> all outputs zero immediately; next clean transaction returns correct plaintext.

Source files
------------

// File: rtl/aes_red_pkg.sv
// Shared types and constants for the redundant AES-128 decryption wrapper.
package aes_red_pkg;

  localparam int BLK_W = 128;
  localparam int ERR_W = 16;

  localparam logic [BLK_W-1:0] ZERO_BLK = '0;

  // Control FSM of the redundancy wrapper.
  typedef enum logic [2:0] {
    IDLE,
    RUN_AB,
    CMP,
    RUN_C,
    VOTE,
    OUT
  } state_t;

  // Majority-vote selection codes.
  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_NONE = 2'd2;

endpackage

// File: rtl/aes_inv_core.sv
// Iterative AES-128 inverse cipher: 10 cycles of forward key expansion to reach
// the last round key, then one decryption round per cycle while walking the key
// schedule backwards. done pulses exactly 22 cycles after the start cycle and
// pt_out holds the result until the next start.
module aes_inv_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ct_in,
  input  logic [127:0] key_in,
  output logic [127:0] pt_out,
  output logic         done
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8 * int'(x) -: 8];
  endfunction

  // The inverse table is derived from the forward one so the two can never disagree.
  function automatic logic [2047:0] build_inv_tbl();
    logic [2047:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      t[2047 - 8 * int'(sbox(8'(i))) -: 8] = 8'(i);
    end
    return t;
  endfunction

  localparam logic [2047:0] INV_TBL = build_inv_tbl();

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_TBL[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int idx);
    case (idx)
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h04;
      3: return 8'h08;
      4: return 8'h10;
      5: return 8'h20;
      6: return 8'h40;
      7: return 8'h80;
      8: return 8'h1b;
      9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)) used by both directions of the key schedule.
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows followed by InvSubBytes; byte r+4c sits at bits 127-8*(r+4c).
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = inv_sbox(s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] s, x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s  = w[31 - 8 * i -: 8];
      x2 = xtime(s);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ s;
      mb[i] = x8 ^ x2 ^ s;
      md[i] = x8 ^ x4 ^ s;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32 * c -: 32] = inv_mix_word(s[127 - 32 * c -: 32]);
    end
    return o;
  endfunction

  logic [127:0] st;
  logic [127:0] rk;
  logic [4:0]   cnt;
  logic         busy;

  // Round sequencer: cnt 0..9 expand key, 10 adds round key 10, 11..19 full rounds, 20 final round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= '0;
      rk   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values, independent of statement order.
      done <= 1'b0;
      if (start) begin
        st   <= ct_in;
        rk   <= key_in;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        cnt <= cnt + 5'd1;
        if (cnt < 5'd10) begin
          rk <= key_fwd(rk, rcon(int'(cnt)));
        end else if (cnt == 5'd10) begin
          st <= st ^ rk;
          rk <= key_bwd(rk, rcon(9));
        end else if (cnt < 5'd20) begin
          st <= inv_mix(inv_shift_sub(st) ^ rk);
          rk <= key_bwd(rk, rcon(19 - int'(cnt)));
        end else begin
          st   <= inv_shift_sub(st) ^ rk;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign pt_out = st;

endmodule

// File: rtl/tmr_vote128.sv
// Combinational 3-way comparator and majority selector for 128-bit blocks.
module tmr_vote128
  import aes_red_pkg::*;
(
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic [BLK_W-1:0] c,
  output logic             ab_eq,
  output logic             ca_eq,
  output logic             cb_eq,
  output logic [1:0]       sel
);

  assign ab_eq = (a == b);
  assign ca_eq = (c == a);
  assign cb_eq = (c == b);

  // Prefer A whenever it agrees with another copy, otherwise B if C backs it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    sel = SEL_NONE;
    if (ab_eq || ca_eq) begin
      sel = SEL_A;
    end else if (cb_eq) begin
      sel = SEL_B;
    end
  end

endmodule

// File: rtl/aes_dec_redundancy.sv
// Fault-tolerant AES-128 decryption: dual-core compare, third-core majority vote
// on disagreement, bounded retries and a per-run timeout.
module aes_dec_redundancy
  import aes_red_pkg::*;
#(
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ciphertext_in,
  input  logic [BLK_W-1:0] key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] plaintext_out,
  output logic             fault_detected,
  output logic             fault_fatal,
  output logic [ERR_W-1:0] err_count
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state, state_nx;
  logic [BLK_W-1:0] ct_q, key_q;
  logic             start_ab, start_c, start_ab_nx, start_c_nx;
  logic             done_a, done_b, done_c, flag_a, flag_b;
  logic [BLK_W-1:0] pt_a, pt_b, pt_c;
  logic             ab_eq, ca_eq, cb_eq;
  logic [1:0]       sel;
  logic [RW-1:0]    retry_q;
  logic [TW-1:0]    tmo_q;
  logic [BLK_W-1:0] pt_q, pt_nx;
  logic             det_q, fat_q, det_nx, fat_nx;
  logic [ERR_W-1:0] err_q;
  logic             accept, load_out, retry_inc, both_done, tmo_hit, out_hs;

  aes_inv_core u_core_a (.clk(clk), .rst_n(rst_n), .start(start_ab), .ct_in(ct_q),
                         .key_in(key_q), .pt_out(pt_a), .done(done_a));
  aes_inv_core u_core_b (.clk(clk), .rst_n(rst_n), .start(start_ab), .ct_in(ct_q),
                         .key_in(key_q), .pt_out(pt_b), .done(done_b));
  aes_inv_core u_core_c (.clk(clk), .rst_n(rst_n), .start(start_c), .ct_in(ct_q),
                         .key_in(key_q), .pt_out(pt_c), .done(done_c));

  tmr_vote128 u_vote (.a(pt_a), .b(pt_b), .c(pt_c), .ab_eq(ab_eq), .ca_eq(ca_eq),
                      .cb_eq(cb_eq), .sel(sel));

  // A done pulse in the current cycle counts, so the flags are not needed to see it.
  assign both_done = (flag_a | done_a) & (flag_b | done_b);
  // The counter is stale in the start cycle itself, so expiry is masked there.
  assign tmo_hit   = !(start_ab | start_c) && (tmo_q == TW'(TIMEOUT));
  assign out_hs    = (state == OUT) && out_ready;

  // Next-state, start pulses and output-register loads.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    load_out    = 1'b0;
    retry_inc   = 1'b0;
    start_ab_nx = 1'b0;
    start_c_nx  = 1'b0;
    pt_nx       = ZERO_BLK;
    det_nx      = 1'b0;
    fat_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept      = 1'b1;
          start_ab_nx = 1'b1;
          state_nx    = RUN_AB;
        end
      end
      RUN_AB: begin
        if (both_done) begin
          state_nx = CMP;
        end else if (tmo_hit) begin
          load_out = 1'b1;
          fat_nx   = 1'b1;
          state_nx = OUT;
        end
      end
      CMP: begin
        if (ab_eq) begin
          load_out = 1'b1;
          pt_nx    = pt_a;
          state_nx = OUT;
        end else begin
          start_c_nx = 1'b1;
          state_nx   = RUN_C;
        end
      end
      RUN_C: begin
        if (done_c) begin
          state_nx = VOTE;
        end else if (tmo_hit) begin
          load_out = 1'b1;
          fat_nx   = 1'b1;
          state_nx = OUT;
        end
      end
      VOTE: begin
        if (ca_eq || cb_eq) begin
          load_out = 1'b1;
          pt_nx    = (sel == SEL_B) ? pt_b : pt_a;
          det_nx   = 1'b1;
          state_nx = OUT;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_inc   = 1'b1;
          start_ab_nx = 1'b1;
          state_nx    = RUN_AB;
        end else begin
          load_out = 1'b1;
          fat_nx   = 1'b1;
          state_nx = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, start pulses, operands and run bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start_ab <= 1'b0;
      start_c  <= 1'b0;
      ct_q     <= ZERO_BLK;
      key_q    <= ZERO_BLK;
      flag_a   <= 1'b0;
      flag_b   <= 1'b0;
      retry_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state    <= state_nx;
      start_ab <= start_ab_nx;
      start_c  <= start_c_nx;
      if (accept) begin
        ct_q    <= ciphertext_in;
        key_q   <= key_in;
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      // Flags clear on the edge that launches a run so old completions never leak in.
      if (start_ab_nx) begin
        flag_a <= 1'b0;
        flag_b <= 1'b0;
      end else begin
        flag_a <= flag_a | done_a;
        flag_b <= flag_b | done_b;
      end
      if (start_ab || start_c) begin
        tmo_q <= TW'(1);
      end else if (state == IDLE) begin
        tmo_q <= '0;
      end else if ((state == RUN_AB || state == RUN_C) && tmo_q != TW'(TIMEOUT)) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  // Result registers: loaded on entry to OUT, held until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q  <= ZERO_BLK;
      det_q <= 1'b0;
      fat_q <= 1'b0;
      err_q <= '0;
    end else begin
      if (load_out) begin
        pt_q  <= pt_nx;
        det_q <= det_nx;
        fat_q <= fat_nx;
      end else if (out_hs) begin
        pt_q  <= ZERO_BLK;
        det_q <= 1'b0;
        fat_q <= 1'b0;
      end
      if (out_hs && (det_q || fat_q) && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign in_ready       = (state == IDLE);
  assign out_valid      = (state == OUT);
  assign plaintext_out  = pt_q;
  assign fault_detected = det_q;
  assign fault_fatal    = fat_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_aes_dec_redundancy.sv
// Directed bench for aes_dec_redundancy using FIPS-197 vectors and forced core faults.
module tb_aes_dec_redundancy;

  localparam int L       = 22;
  localparam int TIMEOUT = 64;
  localparam int BOUND   = 600;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ciphertext_in = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext_out;
  logic         fault_detected;
  logic         fault_fatal;
  logic [15:0]  err_count;

  int checks = 0;
  int errors = 0;

  aes_dec_redundancy #(.MAX_RETRY(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext_in(ciphertext_in), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext_out(plaintext_out),
    .fault_detected(fault_detected), .fault_fatal(fault_fatal), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Present a request at the current negedge; the next posedge is handshake cycle T.
  task automatic drive_req(input logic [127:0] ct, input logic [127:0] key);
    ciphertext_in = ct;
    key_in        = key;
    in_valid      = 1'b1;
  endtask

  // Count negedges after cycle T until out_valid; lat = k means out_valid in cycle T+k.
  task automatic wait_out(output int lat, output bit ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid = 1'b0;
      if (in_ready) ready_seen = 1'b1;
    end while (!out_valid && lat < BOUND);
  endtask

  // Complete the output handshake and land on the following negedge.
  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (plaintext_out !== '0) begin errors++; $display("FAIL reset_plaintext got %h want 0", plaintext_out); end
    checks++;
    if ({fault_detected, fault_fatal} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b want 00", {fault_detected, fault_fatal});
    end
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    checks++;
  endtask

  task automatic test_no_fault();
    int lat;
    bit rdy;
    drive_req(CT1, KEY1);
    wait_out(lat, rdy);
    if (lat != L + 3) begin errors++; $display("FAIL nofault_latency got %0d want %0d", lat, L + 3); end
    checks++;
    if (plaintext_out !== PT1) begin errors++; $display("FAIL nofault_plaintext got %h want %h", plaintext_out, PT1); end
    checks++;
    if ({fault_detected, fault_fatal} !== 2'b00) begin
      errors++; $display("FAIL nofault_flags got %b want 00", {fault_detected, fault_fatal});
    end
    checks++;
    take_out();
    if ({out_valid, in_ready} !== 2'b01 || plaintext_out !== '0) begin
      errors++; $display("FAIL nofault_after_hs got v=%b r=%b pt=%h want v=0 r=1 pt=0", out_valid, in_ready, plaintext_out);
    end
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL nofault_err_count got %0d want 0", err_count); end
    checks++;
  endtask

  task automatic test_single_fault();
    int lat;
    bit rdy;
    force dut.pt_b = PT1 ^ 128'h1;
    drive_req(CT1, KEY1);
    wait_out(lat, rdy);
    if (lat != 2 * L + 5) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, 2 * L + 5); end
    checks++;
    if (plaintext_out !== PT1) begin errors++; $display("FAIL single_plaintext got %h want %h", plaintext_out, PT1); end
    checks++;
    if ({fault_detected, fault_fatal} !== 2'b10) begin
      errors++; $display("FAIL single_flags got %b want 10", {fault_detected, fault_fatal});
    end
    checks++;
    take_out();
    if (err_count !== 16'd1) begin errors++; $display("FAIL single_err_count got %0d want 1", err_count); end
    checks++;
    release dut.pt_b;
  endtask

  task automatic test_all_differ();
    int lat;
    bit rdy;
    force dut.pt_a = 128'haaaa0000aaaa0000aaaa0000aaaa0000;
    force dut.pt_b = 128'hbbbb0000bbbb0000bbbb0000bbbb0000;
    force dut.pt_c = 128'hcccc0000cccc0000cccc0000cccc0000;
    drive_req(CT1, KEY1);
    wait_out(lat, rdy);
    // Three attempts of A/B + C + vote, each 2L+4 cycles, then OUT.
    if (lat != 6 * L + 13) begin errors++; $display("FAIL differ_latency got %0d want %0d", lat, 6 * L + 13); end
    checks++;
    if ({fault_detected, fault_fatal} !== 2'b01) begin
      errors++; $display("FAIL differ_flags got %b want 01", {fault_detected, fault_fatal});
    end
    checks++;
    if (plaintext_out !== '0) begin errors++; $display("FAIL differ_plaintext got %h want 0", plaintext_out); end
    checks++;
    take_out();
    if (err_count !== 16'd2) begin errors++; $display("FAIL differ_err_count got %0d want 2", err_count); end
    checks++;
    release dut.pt_a;
    release dut.pt_b;
    release dut.pt_c;
  endtask

  task automatic test_timeout();
    int lat;
    bit rdy;
    force dut.done_a = 1'b0;
    drive_req(CT1, KEY1);
    wait_out(lat, rdy);
    if (lat != TIMEOUT + 2) begin errors++; $display("FAIL timeout_latency got %0d want %0d", lat, TIMEOUT + 2); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL timeout_in_ready got seen=%b want 0", rdy); end
    checks++;
    if ({fault_detected, fault_fatal} !== 2'b01 || plaintext_out !== '0) begin
      errors++; $display("FAIL timeout_result got flags=%b pt=%h want 01 pt=0", {fault_detected, fault_fatal}, plaintext_out);
    end
    checks++;
    take_out();
    if (err_count !== 16'd3) begin errors++; $display("FAIL timeout_err_count got %0d want 3", err_count); end
    checks++;
    release dut.done_a;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit rdy;
    drive_req(CT1, KEY1);
    wait_out(lat, rdy);
    // Offer a second request while the first result is stalled.
    drive_req(CT2, KEY2);
    for (int i = 0; i < 10; i++) begin
      if ({out_valid, in_ready, fault_detected, fault_fatal} !== 4'b1000 || plaintext_out !== PT1) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b r=%b d=%b f=%b pt=%h want v=1 r=0 d=0 f=0 pt=%h",
                 i, out_valid, in_ready, fault_detected, fault_fatal, plaintext_out, PT1);
      end
      checks++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL b2b_idle got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    checks++;
    wait_out(lat, rdy);
    if (lat != L + 3) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, L + 3); end
    checks++;
    if (plaintext_out !== PT2) begin errors++; $display("FAIL b2b_plaintext got %h want %h", plaintext_out, PT2); end
    checks++;
    take_out();
    if (err_count !== 16'd3) begin errors++; $display("FAIL b2b_err_count got %0d want 3", err_count); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit rdy;
    force dut.pt_b = PT1 ^ 128'h1;
    drive_req(CT1, KEY1);
    // RUN_C spans cycles T+3+L .. T+3+2L.
    for (int i = 0; i < L + 6; i++) begin
      @(negedge clk);
      if (i == 0) in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    if ({out_valid, fault_detected, fault_fatal} !== 3'b000 || plaintext_out !== '0) begin
      errors++; $display("FAIL midreset_outputs got v=%b d=%b f=%b pt=%h want all 0",
                          out_valid, fault_detected, fault_fatal, plaintext_out);
    end
    checks++;
    if (err_count !== 16'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_state got err=%0d r=%b want err=0 r=1", err_count, in_ready);
    end
    checks++;
    @(negedge clk);
    release dut.pt_b;
    rst_n = 1'b1;
    @(negedge clk);
    drive_req(CT2, KEY2);
    wait_out(lat, rdy);
    if (lat != L + 3) begin errors++; $display("FAIL postreset_latency got %0d want %0d", lat, L + 3); end
    checks++;
    if (plaintext_out !== PT2 || {fault_detected, fault_fatal} !== 2'b00) begin
      errors++; $display("FAIL postreset_result got pt=%h flags=%b want pt=%h flags=00",
                          plaintext_out, {fault_detected, fault_fatal}, PT2);
    end
    checks++;
    take_out();
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_single_fault();
    test_all_differ();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
